// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// The tick divider is computed at elaboration time from the line rate and the oversampling factor.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Rounded clk_hz / (baud * os).
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        longint den;
        den = longint'(baud) * longint'(os);
        return int'((longint'(clk_hz) + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, free-running,
// realigned to the start edge by a one-cycle restart pulse.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic sysclk,
    input  logic Reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge sysclk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (restart || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, oversampled majority-vote FSM,
// and a valid/ready holding register with frame, parity and overrun flags.
module uart_rx_param #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 sysclk,
    input  logic                 Reset,
    input  logic                 UART_IN,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    import uart_pkg::rx_state_t;
    import uart_pkg::IDLE;
    import uart_pkg::START;
    import uart_pkg::DATA;
    import uart_pkg::STOP;
    import uart_pkg::WAIT_HIGH;
    import uart_pkg::PAR_NONE;
    import uart_pkg::PAR_ODD;
    import uart_pkg::PAR_EVEN;
    import uart_pkg::calc_div;

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    B_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    B_STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_t            r_state;
    logic [1:0]           r_sync;
    logic                 r_rxs_d;
    logic [TW-1:0]        r_tick_idx;
    logic [3:0]           r_bit_idx;
    logic                 r_s0, r_s1, r_pbit, r_ferr;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_frame_err, r_parity_err, r_overrun;

    logic w_rxs, w_fall, w_restart, w_tick, w_active;
    logic w_vote, w_vote_tick, w_end_tick, w_deliver, w_hs, w_par_x, w_perr;

    assign w_rxs       = r_sync[1];
    assign w_fall      = r_rxs_d & ~w_rxs;
    assign w_restart   = (r_state == IDLE) && w_fall;
    assign w_active    = (r_state != IDLE) && (r_state != WAIT_HIGH);
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_vote_tick = w_tick && (r_tick_idx == T_S2);
    assign w_end_tick  = w_tick && (r_tick_idx == T_END);
    assign w_deliver   = (r_state == STOP) && w_vote_tick && (r_bit_idx == B_STOP_LAST);
    assign w_hs        = r_rx_valid & rx_ready;
    assign w_par_x     = (^r_shift) ^ r_pbit;
    assign w_perr      = (PARITY == PAR_ODD)  ? ~w_par_x :
                         (PARITY == PAR_EVEN) ?  w_par_x : 1'b0;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .sysclk  (sysclk),
        .Reset   (Reset),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_ff @(posedge sysclk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_sync       <= 2'b11;
            r_rxs_d      <= 1'b1;
            r_tick_idx   <= '0;
            r_bit_idx    <= '0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_pbit       <= 1'b0;
            r_ferr       <= 1'b0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], UART_IN};
            r_rxs_d <= w_rxs;

            if (w_active && w_tick) begin
                r_tick_idx <= (r_tick_idx == T_END) ? '0 : r_tick_idx + 1'b1;
                if (r_tick_idx == T_S0) r_s0 <= w_rxs;
                if (r_tick_idx == T_S1) r_s1 <= w_rxs;
            end

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state    <= START;
                        r_tick_idx <= '0;
                        r_ferr     <= 1'b0;
                    end
                end
                START: begin
                    if (w_vote_tick && w_vote) begin
                        r_state <= IDLE;
                    end else if (w_end_tick) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (w_vote_tick) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_end_tick) begin
                        if (r_bit_idx == B_DATA_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (w_vote_tick) r_pbit <= w_vote;
                    if (w_end_tick) begin
                        r_bit_idx <= '0;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_vote_tick) begin
                        r_ferr <= r_ferr | ~w_vote;
                        if (r_bit_idx == B_STOP_LAST) r_state <= w_vote ? IDLE : WAIT_HIGH;
                    end else if (w_end_tick) begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (w_rxs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // NOTE: the delivery assignments come after the handshake clear so a
            // simultaneous delivery overrides it (last non-blocking write wins).
            if (w_hs) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
            if (w_deliver) begin
                if (!r_rx_valid || w_hs) begin
                    r_rx_data    <= r_shift;
                    r_frame_err  <= r_ferr | ~w_vote;
                    r_parity_err <= w_perr;
                    r_rx_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance at 16 cycles per bit,
// with hand-computed expected words and flags.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_n = 1'b1, line_e = 1'b1;
    logic       ready_n = 1'b1, ready_e = 1'b1;
    logic [7:0] data_n, data_e;
    logic       valid_n, valid_e, ferr_n, ferr_e, perr_n, perr_e, ovr_n, ovr_e, busy_n, busy_e;

    int total = 0;
    int bad   = 0;

    // Monitor state: words counted on each rising edge of rx_valid, flags captured there.
    int         words_n = 0, vcyc_n = 0, words_e = 0;
    logic       prev_n = 1'b0, prev_e = 1'b0;
    logic [7:0] cap_data_n = '0, cap_data_e = '0;
    logic       cap_ferr_n = 1'b0, cap_perr_n = 1'b0, cap_ferr_e = 1'b0, cap_perr_e = 1'b0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_n (
        .sysclk(clk), .Reset(rst), .UART_IN(line_n),
        .rx_data(data_n), .rx_valid(valid_n), .rx_ready(ready_n),
        .frame_err(ferr_n), .parity_err(perr_n), .overrun(ovr_n), .busy(busy_n)
    );

    uart_rx_param #(
        .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dut_e (
        .sysclk(clk), .Reset(rst), .UART_IN(line_e),
        .rx_data(data_e), .rx_valid(valid_e), .rx_ready(ready_e),
        .frame_err(ferr_e), .parity_err(perr_e), .overrun(ovr_e), .busy(busy_e)
    );

    always @(negedge clk) begin
        if (valid_n) begin
            vcyc_n = vcyc_n + 1;
            if (!prev_n) begin
                words_n    = words_n + 1;
                cap_data_n = data_n;
                cap_ferr_n = ferr_n;
                cap_perr_n = perr_n;
            end
        end
        prev_n = valid_n;
        if (valid_e && !prev_e) begin
            words_e    = words_e + 1;
            cap_data_e = data_e;
            cap_ferr_e = ferr_e;
            cap_perr_e = perr_e;
        end
        prev_e = valid_e;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic logic [15:0] fr8n1(input logic [7:0] d);
        return {6'h3F, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] fr8e1(input logic [7:0] d, input logic p);
        return {5'h1F, 1'b1, p, d, 1'b0};
    endfunction

    // Drives n bits LSB first, 16 cycles each, starting and ending on a falling clock edge.
    task automatic send_bits(input bit sel, input logic [15:0] bits, input int n,
                             input int spike_bit, input int spike_cyc);
        logic v;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 16; c++) begin
                v = bits[i];
                if (i == spike_bit && c == spike_cyc) v = 1'b0;
                if (sel) line_e = v; else line_n = v;
                @(negedge clk);
            end
        end
        if (sel) line_e = 1'b1; else line_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        total++; if (data_n !== 8'h00) begin bad++; $display("FAIL reset_data_n: got %h want 00", data_n); end
        total++; if ({valid_n, ferr_n, perr_n, ovr_n, busy_n} !== 5'b0) begin bad++; $display("FAIL reset_flags_n: got %b want 00000", {valid_n, ferr_n, perr_n, ovr_n, busy_n}); end
        total++; if (data_e !== 8'h00) begin bad++; $display("FAIL reset_data_e: got %h want 00", data_e); end
        total++; if ({valid_e, ferr_e, perr_e, ovr_e, busy_e} !== 5'b0) begin bad++; $display("FAIL reset_flags_e: got %b want 00000", {valid_e, ferr_e, perr_e, ovr_e, busy_e}); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_8n1;
        int w0, v0;
        w0 = words_n; v0 = vcyc_n;
        ready_n = 1'b1;
        send_bits(0, fr8n1(8'hA5), 10, -1, 0);
        idle(20);
        total++; if (words_n - w0 !== 1) begin bad++; $display("FAIL 8n1_words: got %0d want 1", words_n - w0); end
        total++; if (vcyc_n - v0 !== 1) begin bad++; $display("FAIL 8n1_valid_pulse: got %0d cycles want 1", vcyc_n - v0); end
        total++; if (cap_data_n !== 8'hA5) begin bad++; $display("FAIL 8n1_data: got %h want a5", cap_data_n); end
        total++; if ({cap_ferr_n, cap_perr_n} !== 2'b00) begin bad++; $display("FAIL 8n1_flags: got %b want 00", {cap_ferr_n, cap_perr_n}); end
        total++; if ({valid_n, busy_n} !== 2'b00) begin bad++; $display("FAIL 8n1_after: valid/busy got %b want 00", {valid_n, busy_n}); end
    endtask

    task automatic test_parity;
        int w0;
        w0 = words_e;
        ready_e = 1'b1;
        send_bits(1, fr8e1(8'h03, 1'b1), 11, -1, 0);
        idle(20);
        total++; if (cap_data_e !== 8'h03) begin bad++; $display("FAIL par1_data: got %h want 03", cap_data_e); end
        total++; if ({cap_perr_e, cap_ferr_e} !== 2'b10) begin bad++; $display("FAIL par1_flags: perr/ferr got %b want 10", {cap_perr_e, cap_ferr_e}); end
        send_bits(1, fr8e1(8'h03, 1'b0), 11, -1, 0);
        idle(20);
        total++; if (cap_data_e !== 8'h03) begin bad++; $display("FAIL par0_data: got %h want 03", cap_data_e); end
        total++; if ({cap_perr_e, cap_ferr_e} !== 2'b00) begin bad++; $display("FAIL par0_flags: perr/ferr got %b want 00", {cap_perr_e, cap_ferr_e}); end
        total++; if (words_e - w0 !== 2) begin bad++; $display("FAIL par_words: got %0d want 2", words_e - w0); end
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = words_n;
        ready_n = 1'b1;
        send_bits(0, fr8n1(8'h81), 10, -1, 0);
        send_bits(0, fr8n1(8'h42), 10, -1, 0);
        idle(20);
        total++; if (words_n - w0 !== 2) begin bad++; $display("FAIL b2b_words: got %0d want 2", words_n - w0); end
        total++; if (cap_data_n !== 8'h42) begin bad++; $display("FAIL b2b_data: got %h want 42", cap_data_n); end
    endtask

    task automatic test_overrun;
        ready_n = 1'b0;
        send_bits(0, fr8n1(8'h55), 10, -1, 0);
        send_bits(0, fr8n1(8'h66), 10, -1, 0);
        idle(20);
        total++; if (valid_n !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", valid_n); end
        total++; if (data_n !== 8'h55) begin bad++; $display("FAIL ovr_data_held: got %h want 55", data_n); end
        total++; if (ovr_n !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", ovr_n); end
        ready_n = 1'b1;
        @(negedge clk);
        ready_n = 1'b0;
        idle(2);
        total++; if ({valid_n, ovr_n} !== 2'b00) begin bad++; $display("FAIL ovr_cleared: valid/overrun got %b want 00", {valid_n, ovr_n}); end
        ready_n = 1'b1;
    endtask

    task automatic test_glitch;
        int w0;
        w0 = words_n;
        line_n = 1'b0;
        idle(2);
        total++; if (busy_n !== 1'b0) begin bad++; $display("FAIL busy_latency_2: got %b want 0", busy_n); end
        idle(1);
        total++; if (busy_n !== 1'b1) begin bad++; $display("FAIL busy_latency_3: got %b want 1", busy_n); end
        idle(1);
        line_n = 1'b1;
        idle(40);
        total++; if ({busy_n, valid_n} !== 2'b00) begin bad++; $display("FAIL glitch_idle: busy/valid got %b want 00", {busy_n, valid_n}); end
        total++; if (words_n - w0 !== 0) begin bad++; $display("FAIL glitch_words: got %0d want 0", words_n - w0); end
        // One-cycle low spike in the middle of data bit 0 (a 1 for 0xA5).
        send_bits(0, fr8n1(8'hA5), 10, 1, 9);
        idle(20);
        total++; if (cap_data_n !== 8'hA5) begin bad++; $display("FAIL spike_data: got %h want a5", cap_data_n); end
        total++; if (words_n - w0 !== 1) begin bad++; $display("FAIL spike_words: got %0d want 1", words_n - w0); end
    endtask

    task automatic test_break;
        int w0;
        w0 = words_n;
        line_n = 1'b0;
        idle(20 * 16);
        total++; if (words_n - w0 !== 1) begin bad++; $display("FAIL break_words: got %0d want 1", words_n - w0); end
        total++; if (cap_data_n !== 8'h00) begin bad++; $display("FAIL break_data: got %h want 00", cap_data_n); end
        total++; if (cap_ferr_n !== 1'b1) begin bad++; $display("FAIL break_ferr: got %b want 1", cap_ferr_n); end
        total++; if (busy_n !== 1'b1) begin bad++; $display("FAIL break_wait_high: busy got %b want 1", busy_n); end
        line_n = 1'b1;
        idle(20);
        total++; if (busy_n !== 1'b0) begin bad++; $display("FAIL break_release: busy got %b want 0", busy_n); end
        send_bits(0, fr8n1(8'h7E), 10, -1, 0);
        idle(20);
        total++; if ({cap_data_n, cap_ferr_n} !== {8'h7E, 1'b0}) begin bad++; $display("FAIL break_next: data/ferr got %h/%b want 7e/0", cap_data_n, cap_ferr_n); end
        total++; if (words_n - w0 !== 2) begin bad++; $display("FAIL break_next_words: got %0d want 2", words_n - w0); end
    endtask

    task automatic test_reset_mid;
        int w0;
        ready_n = 1'b0;
        send_bits(0, fr8n1(8'h11), 10, -1, 0);
        idle(20);
        total++; if ({valid_n, data_n} !== {1'b1, 8'h11}) begin bad++; $display("FAIL rmid_held: valid/data got %b/%h want 1/11", valid_n, data_n); end
        send_bits(0, fr8n1(8'hC3), 5, -1, 0);
        total++; if (busy_n !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b want 1", busy_n); end
        rst = 1'b1;
        #1;
        total++; if (data_n !== 8'h00) begin bad++; $display("FAIL rmid_data: got %h want 00", data_n); end
        total++; if ({valid_n, ferr_n, perr_n, ovr_n, busy_n} !== 5'b0) begin bad++; $display("FAIL rmid_flags: got %b want 00000", {valid_n, ferr_n, perr_n, ovr_n, busy_n}); end
        idle(3);
        rst = 1'b0;
        w0 = words_n;
        ready_n = 1'b1;
        idle(200);
        total++; if (words_n - w0 !== 0) begin bad++; $display("FAIL rmid_no_word: got %0d want 0", words_n - w0); end
        send_bits(0, fr8n1(8'h3C), 10, -1, 0);
        idle(20);
        total++; if (cap_data_n !== 8'h3C) begin bad++; $display("FAIL rmid_next: got %h want 3c", cap_data_n); end
        total++; if (words_n - w0 !== 1) begin bad++; $display("FAIL rmid_next_words: got %0d want 1", words_n - w0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
